// File: rtl/posta_pkg.sv
// Shared constants and the requantisation helper for the PosTA post-transform stage.
package posta_pkg;

  localparam int TILE_IN  = 4;
  localparam int TILE_OUT = 2;

  // Working width of the requant helper. It must exceed ACC_E+4 for every configuration in use.
  localparam int SAT_W = 96;

  // Winograd F(2x2,3x3) output transform A^T. The right-hand A is the same table transposed.
  localparam int AT [TILE_OUT][TILE_IN] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

  // Round half-up, arithmetic shift right, then clamp to the signed out_w range.
  function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] val,
                                                         input int shift, input int out_w);
    logic signed [SAT_W-1:0] r, hi, lo;
    r = val;
    if (shift > 0) r = r + (SAT_W'(1) <<< (shift - 1));
    r  = r >>> shift;
    hi = (SAT_W'(1) <<< (out_w - 1)) - SAT_W'(1);
    lo = -(SAT_W'(1) <<< (out_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/posta_accum_if.sv
// Input product stream and output tile handshake of the PosTA stage.
interface posta_accum_if #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
);
  import posta_pkg::*;

  logic                                         valid_in;
  logic [TILE_IN-1:0][TILE_IN-1:0][ACC_W-1:0]   u_in;
  logic                                         valid_out;
  logic                                         ready_out;
  logic [TILE_OUT-1:0][TILE_OUT-1:0][OUT_W-1:0] y_out;

  modport master (output valid_in, u_in, ready_out, input valid_out, y_out);
  modport slave  (input valid_in, u_in, ready_out, output valid_out, y_out);
endinterface

// File: rtl/posta_inv_xform.sv
// Inverse Winograd transform Y = A^T*S1*A: registered row stage, then the column stage and
// requantisation as combinational logic feeding the parent's output register.
module posta_inv_xform
  import posta_pkg::*;
#(
  parameter int ACC_E = 38,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         v1,
  input  logic [TILE_IN-1:0][TILE_IN-1:0][ACC_E-1:0]   s1,
  output logic                                         v2,
  output logic [TILE_OUT-1:0][TILE_OUT-1:0][OUT_W-1:0] z
);
  localparam int RW = ACC_E + 2;
  localparam int ZW = ACC_E + 4;

  logic [TILE_OUT-1:0][TILE_IN-1:0][RW-1:0] s2_d, s2;

  // Row stage: combine the four input rows per column using the A^T table.
  always_comb begin
    logic signed [RW-1:0] t;
    t    = '0;
    s2_d = '0;
    for (int i = 0; i < TILE_OUT; i++) begin
      for (int c = 0; c < TILE_IN; c++) begin
        t = '0;
        for (int k = 0; k < TILE_IN; k++) begin
          if (AT[i][k] == 1)       t = t + RW'($signed(s1[k][c]));
          else if (AT[i][k] == -1) t = t - RW'($signed(s1[k][c]));
        end
        s2_d[i][c] = t;
      end
    end
  end

  // Register the row stage; its valid trails v1 by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2 <= '0;
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) s2 <= s2_d;
    end
  end

  // Column stage plus round/shift/saturate into the output pixel width.
  always_comb begin
    logic signed [ZW-1:0] t;
    t = '0;
    z = '0;
    for (int r = 0; r < TILE_OUT; r++) begin
      for (int j = 0; j < TILE_OUT; j++) begin
        t = '0;
        for (int l = 0; l < TILE_IN; l++) begin
          if (AT[j][l] == 1)       t = t + ZW'($signed(s2[r][l]));
          else if (AT[j][l] == -1) t = t - ZW'($signed(s2[r][l]));
        end
        z[r][j] = OUT_W'(sat_shift(SAT_W'(t), SHIFT, OUT_W));
      end
    end
  end

endmodule

// File: rtl/posta_accum.sv
// PosTA top: accumulates N_CH product tiles, hands the sum to the inverse transform and
// holds each finished 2x2 tile until downstream takes it.
module posta_accum
  import posta_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int N_CH  = 36,
  parameter int SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  posta_accum_if.slave         bus,
  output logic [$clog2(N_CH):0] ch_cnt,
  output logic                 overrun
);
  localparam int CW    = $clog2(N_CH) + 1;
  localparam int ACC_E = ACC_W + $clog2(N_CH);

  logic [TILE_IN-1:0][TILE_IN-1:0][ACC_E-1:0]   acc, sum, s1;
  logic [TILE_OUT-1:0][TILE_OUT-1:0][OUT_W-1:0] z;
  logic first, last, v1, v2;

  assign first = (ch_cnt == '0);
  assign last  = (ch_cnt == CW'(N_CH - 1));

  // Running sum; the first beat of a tile replaces the stale accumulator contents.
  always_comb begin
    sum = '0;
    for (int r = 0; r < TILE_IN; r++)
      for (int c = 0; c < TILE_IN; c++)
        sum[r][c] = (first ? '0 : acc[r][c]) + ACC_E'($signed(bus.u_in[r][c]));
  end

  // Channel counter and accumulator; the last beat launches the tile into S1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt <= '0;
      acc    <= '0;
      s1     <= '0;
      v1     <= 1'b0;
    end else begin
      v1 <= 1'b0;
      if (clr) begin
        ch_cnt <= '0;
      end else if (bus.valid_in) begin
        acc <= sum;
        if (last) begin
          s1     <= sum;
          v1     <= 1'b1;
          ch_cnt <= '0;
        end else begin
          ch_cnt <= ch_cnt + CW'(1);
        end
      end
    end
  end

  posta_inv_xform #(
    .ACC_E (ACC_E),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_xform (
    .clk (clk),
    .rst (rst),
    .v1  (v1),
    .s1  (s1),
    .v2  (v2),
    .z   (z)
  );

  // Output holding register: a stalled tile is never overwritten, the newcomer is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_out <= 1'b0;
      bus.y_out     <= '0;
      overrun       <= 1'b0;
    end else if (v2) begin
      if (!bus.valid_out || bus.ready_out) begin
        bus.y_out     <= z;
        bus.valid_out <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (bus.valid_out && bus.ready_out) begin
      bus.valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_posta_accum.sv
// Bench for posta_accum: three instances (N_CH=4/SHIFT=0, N_CH=4/SHIFT=2, N_CH=1/SHIFT=0),
// directed vectors plus random traffic against a matrix-level reference model.
module tb_posta_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic clr_ab = 1'b0, clr_c = 1'b0;
  logic vin_ab = 1'b0, vin_c = 1'b0;
  logic rdy_ab = 1'b1, rdy_c = 1'b1;
  logic [3:0][3:0][31:0] u_ab = '0, u_c = '0;
  logic [2:0] cnt_a, cnt_b;
  logic [0:0] cnt_c;
  logic ovr_a, ovr_b, ovr_c;

  posta_accum_if #(.ACC_W(32), .OUT_W(16)) ia ();
  posta_accum_if #(.ACC_W(32), .OUT_W(16)) ib ();
  posta_accum_if #(.ACC_W(32), .OUT_W(16)) ic ();

  assign ia.valid_in = vin_ab;  assign ia.u_in = u_ab;  assign ia.ready_out = rdy_ab;
  assign ib.valid_in = vin_ab;  assign ib.u_in = u_ab;  assign ib.ready_out = rdy_ab;
  assign ic.valid_in = vin_c;   assign ic.u_in = u_c;   assign ic.ready_out = rdy_c;

  posta_accum #(.ACC_W(32), .OUT_W(16), .N_CH(4), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr_ab), .bus(ia), .ch_cnt(cnt_a), .overrun(ovr_a));
  posta_accum #(.ACC_W(32), .OUT_W(16), .N_CH(4), .SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .clr(clr_ab), .bus(ib), .ch_cnt(cnt_b), .overrun(ovr_b));
  posta_accum #(.ACC_W(32), .OUT_W(16), .N_CH(1), .SHIFT(0)) dut_c (
    .clk(clk), .rst(rst), .clr(clr_c), .bus(ic), .ch_cnt(cnt_c), .overrun(ovr_c));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int at [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
  int nch [3] = '{4, 4, 1};
  int shf [3] = '{0, 2, 0};

  int     mcnt [3];
  longint macc [3][4][4];
  bit     mpv  [3][2];       // tiles in flight, slot 1 reaches the output next edge
  int     mpy  [3][2][4];
  bit     mvout[3];
  int     my   [3][4];
  bit     movr [3];

  function automatic void ref_tile(input longint u[4][4], input int shift, output int y[4]);
    longint t;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        t = 0;
        for (int k = 0; k < 4; k++)
          for (int l = 0; l < 4; l++)
            t += at[i][k] * u[k][l] * at[j][l];
        if (shift > 0) t += longint'(1) << (shift - 1);
        t = t >>> shift;
        if (t > 32767)  t = 32767;
        if (t < -32768) t = -32768;
        y[i*2+j] = int'(t);
      end
  endfunction

  task automatic model_reset(input int i);
    mcnt[i] = 0; mvout[i] = 0; movr[i] = 0;
    for (int s = 0; s < 2; s++) mpv[i][s] = 0;
    for (int e = 0; e < 4; e++) my[i][e] = 0;
  endtask

  task automatic model_step(input int i, input bit vin, input logic [3:0][3:0][31:0] u,
                            input bit clr, input bit rdy);
    longint a[4][4];
    int yt[4];
    if (mpv[i][1]) begin
      if (!mvout[i] || rdy) begin
        mvout[i] = 1;
        for (int e = 0; e < 4; e++) my[i][e] = mpy[i][1][e];
      end else movr[i] = 1;
    end else if (mvout[i] && rdy) mvout[i] = 0;
    mpv[i][1] = mpv[i][0];
    for (int e = 0; e < 4; e++) mpy[i][1][e] = mpy[i][0][e];
    mpv[i][0] = 0;
    if (clr) mcnt[i] = 0;
    else if (vin) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          macc[i][r][c] = (mcnt[i] == 0 ? 64'sd0 : macc[i][r][c]) + longint'($signed(u[r][c]));
      if (mcnt[i] == nch[i] - 1) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) a[r][c] = macc[i][r][c];
        ref_tile(a, shf[i], yt);
        mpv[i][0] = 1;
        for (int e = 0; e < 4; e++) mpy[i][0][e] = yt[e];
        mcnt[i] = 0;
      end else mcnt[i]++;
    end
  endtask

  task automatic check_inst(input int i, input string nm, input logic vo,
                            input logic [1:0][1:0][15:0] y, input logic [2:0] cnt, input logic ovr);
    chk($sformatf("%s.valid_out", nm), vo, mvout[i]);
    for (int e = 0; e < 4; e++)
      chk($sformatf("%s.y%0d", nm, e), $signed(y[e/2][e%2]), my[i][e]);
    chk($sformatf("%s.ch_cnt", nm), cnt, mcnt[i]);
    chk($sformatf("%s.overrun", nm), ovr, movr[i]);
  endtask

  // Compare every instance each cycle, then advance the model over the coming edge.
  always @(negedge clk) begin
    if (rst) for (int i = 0; i < 3; i++) model_reset(i);
    check_inst(0, "m.a", ia.valid_out, ia.y_out, cnt_a, ovr_a);
    check_inst(1, "m.b", ib.valid_out, ib.y_out, cnt_b, ovr_b);
    check_inst(2, "m.c", ic.valid_out, ic.y_out, {2'b00, cnt_c}, ovr_c);
    if (!rst) begin
      model_step(0, vin_ab, u_ab, clr_ab, rdy_ab);
      model_step(1, vin_ab, u_ab, clr_ab, rdy_ab);
      model_step(2, vin_c, u_c, clr_c, rdy_c);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int val;
    int ya[4];
    int yb[4];
  } vec_t;
  vec_t vt[6];

  task automatic set_vec(input int n, input int v, input int a0, input int a1, input int a2,
                         input int a3, input int b0, input int b1, input int b2, input int b3);
    vt[n].val = v;
    vt[n].ya[0] = a0; vt[n].ya[1] = a1; vt[n].ya[2] = a2; vt[n].ya[3] = a3;
    vt[n].yb[0] = b0; vt[n].yb[1] = b1; vt[n].yb[2] = b2; vt[n].yb[3] = b3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(output logic [3:0][3:0][31:0] u, input int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) u[r][c] = v;
  endtask

  function automatic int rnd_val();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 2000)) - 1000;
  endfunction

  task automatic chk_a36(input string nm);
    chk({nm, ".valid"}, ia.valid_out, 1);
    chk({nm, ".y00"}, $signed(ia.y_out[0][0]), 36);
    chk({nm, ".y01"}, $signed(ia.y_out[0][1]), -12);
    chk({nm, ".y10"}, $signed(ia.y_out[1][0]), -12);
    chk({nm, ".y11"}, $signed(ia.y_out[1][1]), 4);
  endtask

  initial begin
    set_vec(0, 1,      36, -12, -12, 4,            9, -3, -3, 1);
    set_vec(1, 32767,  32767, -32768, -32768, 32767, 32767, -32768, -32768, 32767);
    set_vec(2, -1,     -36, 12, 12, -4,            -9, 3, 3, -1);
    set_vec(3, 2,      72, -24, -24, 8,            18, -6, -6, 2);
    set_vec(4, 3,      108, -36, -36, 12,          27, -9, -9, 3);
    set_vec(5, -32768, -32768, 32767, 32767, -32768, -32768, 32767, 32767, -32768);

    repeat (3) tick();
    chk("rst.valid_out", ia.valid_out, 0);
    chk("rst.y_out", ia.y_out, 0);
    chk("rst.ch_cnt", cnt_a, 0);
    chk("rst.overrun", ovr_a, 0);
    rst = 1'b0;
    tick();

    // Table vectors: four equal beats, two-edge latency, then a handshake empties the register.
    for (int n = 0; n < 6; n++) begin
      rdy_ab = 1'b1;
      fill(u_ab, vt[n].val);
      vin_ab = 1'b1;
      repeat (4) tick();
      vin_ab = 1'b0;
      chk($sformatf("vec%0d.lat0", n), ia.valid_out, 0);
      tick();
      chk($sformatf("vec%0d.lat1", n), ia.valid_out, 0);
      tick();
      chk($sformatf("vec%0d.valid_a", n), ia.valid_out, 1);
      chk($sformatf("vec%0d.valid_b", n), ib.valid_out, 1);
      for (int e = 0; e < 4; e++) begin
        chk($sformatf("vec%0d.ya%0d", n, e), $signed(ia.y_out[e/2][e%2]), vt[n].ya[e]);
        chk($sformatf("vec%0d.yb%0d", n, e), $signed(ib.y_out[e/2][e%2]), vt[n].yb[e]);
      end
      tick();
      chk($sformatf("vec%0d.drain", n), ia.valid_out, 0);
    end

    // clr discards a partial tile; a beat coinciding with clr is dropped.
    fill(u_ab, 5);
    vin_ab = 1'b1;
    repeat (2) tick();
    chk("clr.cnt_before", cnt_a, 2);
    clr_ab = 1'b1;
    tick();
    clr_ab = 1'b0;
    chk("clr.cnt_after", cnt_a, 0);
    fill(u_ab, 1);
    repeat (4) tick();
    vin_ab = 1'b0;
    repeat (2) tick();
    chk_a36("clr");

    // Async reset mid-tile clears outputs immediately; the following tile is clean.
    vin_ab = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    chk("arst.valid_out", ia.valid_out, 0);
    chk("arst.y_out", ia.y_out, 0);
    chk("arst.ch_cnt", cnt_a, 0);
    chk("arst.overrun", ovr_a, 0);
    vin_ab = 1'b0;
    tick();
    rst = 1'b0;
    vin_ab = 1'b1;
    repeat (4) tick();
    vin_ab = 1'b0;
    repeat (2) tick();
    chk_a36("arst");

    // Overrun with N_CH=1: second tile dropped while the first is stalled.
    rdy_c = 1'b0;
    fill(u_c, 1);
    vin_c = 1'b1;
    tick();
    fill(u_c, 2);
    tick();
    vin_c = 1'b0;
    tick();
    chk("ovr.valid", ic.valid_out, 1);
    chk("ovr.early", ovr_c, 0);
    tick();
    chk("ovr.flag", ovr_c, 1);
    chk("ovr.y00", $signed(ic.y_out[0][0]), 9);
    chk("ovr.y01", $signed(ic.y_out[0][1]), -3);
    chk("ovr.y10", $signed(ic.y_out[1][0]), -3);
    chk("ovr.y11", $signed(ic.y_out[1][1]), 1);
    rdy_c = 1'b1;
    tick();
    chk("ovr.handshake", ic.valid_out, 0);
    chk("ovr.y_hold", $signed(ic.y_out[0][0]), 9);
    chk("ovr.sticky", ovr_c, 1);
    repeat (2) tick();
    chk("ovr.quiet", ic.valid_out, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovr.cleared", ovr_c, 0);

    // Continuous N_CH=1 traffic with ready held high: a fresh tile every cycle.
    for (int j = 0; j < 10; j++) begin
      fill(u_c, j + 1);
      vin_c = 1'b1;
      tick();
      if (j >= 2) begin
        chk($sformatf("cont%0d.valid", j), ic.valid_out, 1);
        chk($sformatf("cont%0d.y00", j), $signed(ic.y_out[0][0]), 9 * (j - 1));
      end
    end
    vin_c = 1'b0;
    chk("cont.overrun", ovr_c, 0);

    // Random traffic checked by the model each cycle.
    for (int n = 0; n < 3000; n++) begin
      vin_ab = ($urandom_range(0, 9) < 8);
      vin_c  = ($urandom_range(0, 9) < 7);
      clr_ab = ($urandom_range(0, 39) == 0);
      clr_c  = ($urandom_range(0, 39) == 0);
      rdy_ab = ($urandom_range(0, 9) < 7);
      rdy_c  = ($urandom_range(0, 9) < 6);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          u_ab[r][c] = rnd_val();
          u_c[r][c]  = rnd_val();
        end
      rst = (n == 1500);
      tick();
    end
    rst = 1'b0;
    vin_ab = 1'b0; vin_c = 1'b0; clr_ab = 1'b0; clr_c = 1'b0;
    rdy_ab = 1'b1; rdy_c = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
